fifo_wptr_full: RTL and testbench
=================================

# fifo_wptr_full

Write-domain pointer and status generator for the async FIFO. It owns the binary write address and the Gray-coded write pointer that crosses to the read domain. It compares the next write pointer with the two-flop-synchronized read pointer to produce registered `full`, `near_full`, `overflow` and occupancy. It sits between the write-side client (`winc`) and the dual-port memory, and feeds the write-pointer assertion checker and the read-domain synchronizer.

## Interface
- `ASIZE`, 4, address width; FIFO depth DEPTH = 2**ASIZE; legal range ≥ 2.
- `NF_MARGIN`, 3, near-full window width in entries; legal 1..DEPTH-1.
- `wclk` in 1: write clock; the only clock in the block.
- `wrst_n` in 1: reset, asynchronous assert, active-low.
- `winc` in 1: write request from the client.
- `wq2_rptr` in ASIZE+1: Gray read pointer, already synchronized into wclk.
- `wen` out 1: memory write enable, combinational, = `winc & !full`.
- `waddr` out ASIZE: memory write address, = low ASIZE bits of binary write pointer.
- `wptr` out ASIZE+1: registered Gray write pointer, sent to the read-domain synchronizer.
- `full` out 1: registered; FIFO holds DEPTH entries.
- `near_full` out 1: registered; occupancy in [DEPTH-NF_MARGIN, DEPTH-1].
- `overflow` out 1: registered one-cycle pulse for a dropped write.
- `wcount` out ASIZE+1: registered occupancy as seen by the write domain, 0..DEPTH.

## Operation
- Internal state: `wbin` (ASIZE+1 binary), `wptr`, `full`, `near_full`, `overflow`, `wcount`.
- Accepted write: `winc & !full`. `wbinnext = wbin + accepted`. `wgraynext = (wbinnext >> 1) ^ wbinnext`.
- Read pointer: `rbin = gray2bin(wq2_rptr)`. `occ_next = wbinnext - rbin`, computed modulo 2**(ASIZE+1) and ASIZE+1 bits wide. The result is never above DEPTH.
- Full condition: `wgraynext == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]}`. This is equivalent to `occ_next == DEPTH`.
- Near-full condition: `!full_next && occ_next >= DEPTH-NF_MARGIN`. `full` and `near_full` are mutually exclusive by construction.
- Overflow: `overflow <= winc & full`. A write while full is dropped: `wbin` and `wptr` hold, and `wen` stays 0. The protocol forbids this case, but the block must tolerate it.
- Every register updates on every `wclk` edge. Status is recomputed even with no write, so read-side progress clears `full` and `near_full`.
- Pointer wrap-around: `wbin` wraps from 2**(ASIZE+1)-1 to 0. The MSB toggle distinguishes full from empty. `waddr` wraps every DEPTH writes.

## Timing
- Reset (async, `wrst_n`=0): `wbin`=0, `wptr`=0, `full`=0, `near_full`=0, `overflow`=0, `wcount`=0. `wen` is therefore `winc`.
- Reset may assert mid-operation. All state clears immediately, with no partial update. Release is synchronous to `wclk` via the reset synchronizer upstream.
- `waddr` and `wen` are valid in the cycle of the write. `wptr` advances on the same edge that commits the write.
- `full` asserts on the edge of the write that makes occupancy DEPTH, so the next write in the following cycle is already blocked.
- `full` deasserts on the first edge where `wq2_rptr` reflects a read. That is the read-domain read plus the synchronizer's 2 wclk cycles, plus this edge. Deassertion is pessimistic, never optimistic.
- `overflow` goes high exactly one cycle after `winc & full` and lasts one cycle per offending cycle.
- Simultaneous write and read advance: `occ_next` uses both. Occupancy is unchanged, and status follows `occ_next`.

## Structure
- Shared `fifo_pkg`: function `bin2gray`, function `gray2bin` (parameterized by width), and localparam helper `DEPTH(ASIZE)`. The read-side pointer block reuses the same package.
- Sub-module `fifo_gray2bin` (combinational, XOR-prefix, width parameter) converts `wq2_rptr`. It is the only natural sub-module.
- The assertion checker binds to this block's `wclk`/`wrst_n`/`winc`/`near_full`/`full`/`overflow`.

## Test plan
- Reset with `winc`=1 held → all outputs 0, `wen`=1. After release, first write gives `waddr`=0 and `wptr`=5'b00001 on the next edge.
- Defaults, `wq2_rptr`=0, 16 back-to-back writes:
  - `near_full` rises after write 13 (`wcount`=13) and stays through `wcount`=15.
  - After write 16, `full`=1, `near_full`=0, `wptr`=5'b11000.
- While full, `winc`=1 for 2 cycles → `overflow` high 2 cycles, each lagging by 1. `wen`=0; `wbin` and `wptr` unchanged.
- While full, drive `wq2_rptr`=5'b00001 → next edge: `full`=0, `near_full`=1, `wcount`=15.
- Write continuously 40 times while the read pointer tracks 2 entries behind → `wptr` steps through the Gray sequence with single-bit changes, wraps at 32, and `full` is never asserted.
- Assert `wrst_n` at `wcount`=9 with `winc`=1 → all outputs 0 asynchronously, before the next `wclk` edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: depth from address width and Gray/binary conversion.
// Used by both the write-side and read-side pointer blocks.
package fifo_pkg;

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Only the low 'width' bits of g take part; higher bits are masked off first.
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int width);
    logic [31:0] gm;
    logic [31:0] b;
    gm = g & ((32'd1 << width) - 32'd1);
    b  = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(gm >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module fifo_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < W; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and status generator of the async FIFO: binary write
// address, Gray write pointer, and registered full/near-full/overflow/occupancy.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ASIZE     = 4,
  parameter int NF_MARGIN = 3
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             full,
  output logic             near_full,
  output logic             overflow,
  output logic [ASIZE:0]   wcount
);

  localparam int             DEPTH     = fifo_depth(ASIZE);
  localparam int             PW        = ASIZE + 1;
  localparam logic [ASIZE:0] NF_THRESH = PW'(DEPTH - NF_MARGIN);

  logic [ASIZE:0] wbin_q, wbin_d;
  logic [ASIZE:0] wptr_q, wptr_d;
  logic [ASIZE:0] wcount_q, wcount_d;
  logic [ASIZE:0] rbin;
  logic           full_q, full_d;
  logic           near_full_q, near_full_d;
  logic           overflow_q, overflow_d;

  fifo_gray2bin #(.W(PW)) u_rptr_g2b (
    .gray_i (wq2_rptr),
    .bin_o  (rbin)
  );

  assign wen = winc & ~full_q;

  // Full is the classic Gray compare (top two bits inverted); the subtraction
  // wraps modulo 2**(ASIZE+1) and so yields occupancy directly.
  always_comb begin
    wbin_d      = wbin_q + {{ASIZE{1'b0}}, wen};
    wptr_d      = PW'(bin2gray(32'(wbin_d)));
    wcount_d    = wbin_d - rbin;
    full_d      = (wptr_d == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]});
    near_full_d = ~full_d & (wcount_d >= NF_THRESH);
    overflow_d  = winc & full_q;
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q      <= '0;
      wptr_q      <= '0;
      wcount_q    <= '0;
      full_q      <= 1'b0;
      near_full_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wbin_q      <= wbin_d;
      wptr_q      <= wptr_d;
      wcount_q    <= wcount_d;
      full_q      <= full_d;
      near_full_q <= near_full_d;
      overflow_q  <= overflow_d;
    end
  end

  assign waddr     = wbin_q[ASIZE-1:0];
  assign wptr      = wptr_q;
  assign full      = full_q;
  assign near_full = near_full_q;
  assign overflow  = overflow_q;
  assign wcount    = wcount_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: integer write/read counts model the FIFO and are
// compared with the DUT every cycle, with directed literal checks on top.
module tb_fifo_wptr_full;

  localparam int ASIZE = 4;
  localparam int NF    = 3;
  localparam int DEPTH = 16;

  logic       wclk;
  logic       wrst_n;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       full;
  logic       near_full;
  logic       overflow;
  logic [4:0] wcount;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 0;
  int rdCount  = 0;

  int mWrites = 0;
  int mCount  = 0;
  bit mFull   = 0;
  bit mNear   = 0;
  bit mOvf    = 0;

  fifo_wptr_full #(.ASIZE(ASIZE), .NF_MARGIN(NF)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .winc      (winc),
    .wq2_rptr  (wq2_rptr),
    .wen       (wen),
    .waddr     (waddr),
    .wptr      (wptr),
    .full      (full),
    .near_full (near_full),
    .overflow  (overflow),
    .wcount    (wcount)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [4:0] toGray(input int n);
    logic [4:0] b;
    b = 5'(n % 32);
    return b ^ (b >> 1);
  endfunction

  assign wq2_rptr = toGray(rdCount);

  function automatic int acceptNow();
    return (winc && !mFull) ? 1 : 0;
  endfunction

  function automatic int occAfter();
    return mWrites + acceptNow() - rdCount;
  endfunction

  // Reference: a FIFO is just total writes minus total reads seen so far.
  always @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      mWrites <= 0;
      mCount  <= 0;
      mFull   <= 1'b0;
      mNear   <= 1'b0;
      mOvf    <= 1'b0;
    end else begin
      mWrites <= mWrites + acceptNow();
      mCount  <= occAfter();
      mFull   <= (occAfter() == DEPTH);
      mNear   <= (occAfter() != DEPTH) && (occAfter() >= DEPTH - NF);
      mOvf    <= winc && mFull;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge wclk) begin
    if (checkEn) begin
      checkOutput("wen",       32'(wen),       32'(winc && !mFull));
      checkOutput("waddr",     32'(waddr),     32'(mWrites % DEPTH));
      checkOutput("wptr",      32'(wptr),      32'(toGray(mWrites)));
      checkOutput("full",      32'(full),      32'(mFull));
      checkOutput("near_full", 32'(near_full), 32'(mNear));
      checkOutput("overflow",  32'(overflow),  32'(mOvf));
      checkOutput("wcount",    32'(wcount),    32'(mCount));
    end
  end

  // Inputs change 1 time unit after the rising edge; trackLag >= 0 keeps the
  // read count that many entries behind the committed writes.
  task automatic applyStimulus(input bit w, input int adv, input int trackLag);
    @(posedge wclk);
    #1;
    winc = w;
    if (trackLag >= 0) begin
      if (mWrites - trackLag > rdCount) rdCount = mWrites - trackLag;
    end else begin
      rdCount = rdCount + adv;
    end
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wptr"},     32'(wptr),      32'd0);
    checkOutput({tag, "_waddr"},    32'(waddr),     32'd0);
    checkOutput({tag, "_full"},     32'(full),      32'd0);
    checkOutput({tag, "_near"},     32'(near_full), 32'd0);
    checkOutput({tag, "_overflow"}, 32'(overflow),  32'd0);
    checkOutput({tag, "_wcount"},   32'(wcount),    32'd0);
    checkOutput({tag, "_wen"},      32'(wen),       32'd1);
  endtask

  task automatic randomCycles(input int n);
    for (int i = 0; i < n; i++) begin
      bit w;
      int a;
      w = ($urandom_range(0, 9) < 7);
      a = (rdCount < mWrites && $urandom_range(0, 9) < 4) ? 1 : 0;
      applyStimulus(w, a, -1);
    end
  endtask

  initial begin
    logic [4:0] prevPtr;

    wrst_n  = 1'b0;
    winc    = 1'b1;
    rdCount = 0;
    #3;
    checkAllZero("reset");
    repeat (2) @(posedge wclk);
    #1;
    wrst_n  = 1'b1;
    winc    = 1'b0;
    checkEn = 1;

    applyStimulus(1, 0, -1);
    checkOutput("first_wen",   32'(wen),   32'd1);
    checkOutput("first_waddr", 32'(waddr), 32'd0);

    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1, 0, -1);
      if (k == 1)  checkOutput("first_wptr", 32'(wptr), 32'b00001);
      if (k == 12) checkOutput("nf_12", 32'(near_full), 32'd0);
      if (k == 13) begin
        checkOutput("nf_13",     32'(near_full), 32'd1);
        checkOutput("wcount_13", 32'(wcount),    32'd13);
      end
      if (k == 15) checkOutput("nf_15", 32'(near_full), 32'd1);
    end
    checkOutput("full_16", 32'(full),      32'd1);
    checkOutput("nf_16",   32'(near_full), 32'd0);
    checkOutput("wptr_16", 32'(wptr),      32'b11000);
    checkOutput("wen_full", 32'(wen),      32'd0);

    applyStimulus(1, 0, -1);
    checkOutput("ovf_1",      32'(overflow), 32'd1);
    checkOutput("ovf_wptr_1", 32'(wptr),     32'b11000);
    applyStimulus(0, 0, -1);
    checkOutput("ovf_2",      32'(overflow), 32'd1);
    checkOutput("ovf_wptr_2", 32'(wptr),     32'b11000);
    applyStimulus(0, 1, -1);
    checkOutput("ovf_end",    32'(overflow), 32'd0);
    checkOutput("ovf_waddr",  32'(waddr),    32'd0);
    applyStimulus(0, 0, -1);
    checkOutput("rd_full",   32'(full),      32'd0);
    checkOutput("rd_nf",     32'(near_full), 32'd1);
    checkOutput("rd_wcount", 32'(wcount),    32'd15);

    prevPtr = wptr;
    for (int i = 0; i <= 40; i++) begin
      applyStimulus(1, 0, 2);
      if (i >= 1) begin
        checkOutput("track_gray_step", 32'($countones(prevPtr ^ wptr)), 32'd1);
        checkOutput("track_full",      32'(full), 32'd0);
      end
      prevPtr = wptr;
    end

    randomCycles(400);

    @(posedge wclk);
    #1;
    wrst_n  = 1'b0;
    winc    = 1'b0;
    rdCount = 0;
    repeat (2) @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, -1);
    checkOutput("pre_rst_wcount", 32'(wcount), 32'd9);
    #1;
    wrst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    randomCycles(30);

    checkEn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
